toggle_rx: RTL and testbench

Receiver end of a T-flip-flop toggle link: a sender signals one event per transition of a single toggle wire `t_in`, asynchronous to `clk`. This block synchronizes `t_in`, converts each transition (either direction) into a one-cycle `pulse`, counts events, and flags a stalled sender via a timeout. It sits on the clock domain that consumes events produced by T-FF based senders.

---
 rtl/toggle_rx_if.sv | 25 ++
 rtl/toggle_rx.sv | 115 +++++++++++
 tb/tb_toggle_rx.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/toggle_rx_if.sv
// toggle_rx_if: toggle-link receiver signal bundle.
// The master drives the link and controls; the slave returns events and status.
interface toggle_rx_if #(
    parameter int CNT_W = 8
);
    logic             t_in;
    logic             en;
    logic             cnt_clr;
    logic             pulse;
    logic             level;
    logic [CNT_W-1:0] count;
    logic             ovf;
    logic             timeout;
    logic [2:0]       state;

    modport master (
        output t_in, en, cnt_clr,
        input  pulse, level, count, ovf, timeout, state
    );

    modport slave (
        input  t_in, en, cnt_clr,
        output pulse, level, count, ovf, timeout, state
    );
endinterface

// File: rtl/toggle_rx.sv
// toggle_rx: T-FF toggle link receiver. Synchronizes t_in, emits one pulse
// per transition, counts events and flags a stalled sender.
module toggle_rx #(
    parameter int CNT_W   = 8,
    parameter int TIMEOUT = 16
) (
    input logic        clk,
    input logic        clr,
    toggle_rx_if.slave bus
);
    typedef enum logic [2:0] {
        INIT  = 3'd0,
        IDLE  = 3'd1,
        ARM   = 3'd2,
        RUN   = 3'd3,
        STALL = 3'd4
    } state_e;

    localparam logic [7:0] TLIM = 8'(TIMEOUT - 1);

    state_e           st;
    state_e           st_nxt;
    logic [2:0]       sync;
    logic [7:0]       timer;
    logic [7:0]       timer_nxt;
    logic             pulse_q;
    logic [CNT_W-1:0] cnt_q;
    logic             ovf_q;
    logic             to_q;
    logic             edge_raw;
    logic             active;
    logic             inc;
    logic             fire;

    assign edge_raw = sync[1] ^ sync[2];
    assign inc      = edge_raw & bus.en & active;

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) st <= INIT;
        else      st <= st_nxt;
    end

    always_comb begin
        st_nxt = st;
        unique case (st)
            INIT:  if (timer == 8'd2) st_nxt = bus.en ? ARM : IDLE;
            IDLE:  if (bus.en) st_nxt = ARM;
            ARM: begin
                if (!bus.en)       st_nxt = IDLE;
                else if (edge_raw) st_nxt = RUN;
            end
            RUN: begin
                if (!bus.en)                         st_nxt = IDLE;
                else if (!edge_raw && timer == TLIM) st_nxt = STALL;
            end
            STALL: begin
                if (!bus.en)       st_nxt = IDLE;
                else if (edge_raw) st_nxt = RUN;
            end
            default: st_nxt = INIT;
        endcase
    end

    // The timer doubles as the INIT fill counter; it is frozen in STALL.
    always_comb begin
        active    = 1'b0;
        fire      = 1'b0;
        timer_nxt = '0;
        unique case (st)
            INIT:  timer_nxt = (timer == 8'd2) ? 8'd0 : timer + 8'd1;
            ARM:   active = 1'b1;
            RUN: begin
                active    = 1'b1;
                fire      = bus.en & ~edge_raw & (timer == TLIM);
                timer_nxt = (edge_raw | ~bus.en) ? 8'd0 : timer + 8'd1;
            end
            STALL: begin
                active    = 1'b1;
                timer_nxt = (edge_raw | ~bus.en) ? 8'd0 : timer;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            sync    <= '0;
            timer   <= '0;
            pulse_q <= 1'b0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            to_q    <= 1'b0;
        end else begin
            sync    <= {sync[1:0], bus.t_in};
            timer   <= timer_nxt;
            pulse_q <= inc;
            if (bus.cnt_clr) begin
                cnt_q <= inc ? CNT_W'(1) : '0;
                ovf_q <= 1'b0;
            end else if (inc) begin
                cnt_q <= cnt_q + CNT_W'(1);
                if (&cnt_q) ovf_q <= 1'b1;
            end
            if (fire)             to_q <= 1'b1;
            else if (bus.cnt_clr) to_q <= 1'b0;
        end
    end

    assign bus.pulse   = pulse_q;
    assign bus.level   = sync[2];
    assign bus.count   = cnt_q;
    assign bus.ovf     = ovf_q;
    assign bus.timeout = to_q;
    assign bus.state   = st;
endmodule

// File: tb/tb_toggle_rx.sv
// tb_toggle_rx: directed stimulus for toggle_rx, checked every cycle against
// an event-level model plus hand-computed literal expectations.
module tb_toggle_rx;
    localparam int CNT_W = 4;
    localparam int TO    = 16;

    logic clk = 1'b0;
    logic clr;
    int   n_vec = 0;
    int   n_err = 0;

    toggle_rx_if #(.CNT_W(CNT_W)) bus ();

    toggle_rx #(
        .CNT_W  (CNT_W),
        .TIMEOUT(TO)
    ) dut (
        .clk(clk),
        .clr(clr),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Model: edge index k since reset release, t_in and en as sampled at each edge.
    int               k;
    bit               smp [0:4095];
    bit               ens [0:4095];
    logic [CNT_W-1:0] m_count;
    bit               m_ovf, m_to, m_pulse, m_level, fire;
    bit               have_p, stalled;
    int               last_p;
    int               m_state;

    always @(posedge clk) begin
        if (!clr) begin
            k = 0; smp[0] = 1'b0; ens[0] = 1'b0;
            m_count = '0; m_ovf = 0; m_to = 0; m_pulse = 0; m_level = 0;
            have_p = 0; stalled = 0; last_p = 0; m_state = 0;
        end else if (k < 4095) begin
            k++;
            smp[k] = bus.t_in;
            ens[k] = bus.en;
            // A capture change at k-2 becomes a pulse at k if enabled across k-1..k.
            m_pulse = (k >= 4) && (smp[k-2] != smp[k-3]) && ens[k] && ens[k-1];
            fire = 0;
            if (k < 3 || !ens[k]) begin
                have_p = 0; stalled = 0;
            end else if (m_pulse) begin
                have_p = 1; last_p = k; stalled = 0;
            end else if (have_p && !stalled && (k - last_p) == TO) begin
                fire = 1; stalled = 1;
            end
            if (bus.cnt_clr) begin
                m_count = m_pulse ? CNT_W'(1) : '0;
                m_ovf = 0;
            end else if (m_pulse) begin
                m_count = m_count + CNT_W'(1);
                if (m_count == 0) m_ovf = 1;
            end
            if (fire) m_to = 1;
            else if (bus.cnt_clr) m_to = 0;
            m_level = (k >= 2) ? smp[k-2] : 1'b0;
            if (k < 3)        m_state = 0;
            else if (!ens[k]) m_state = 1;
            else if (!have_p) m_state = 2;
            else if (stalled) m_state = 4;
            else              m_state = 3;
        end
        #1;
        chk("pulse",   int'(bus.pulse),   int'(m_pulse));
        chk("level",   int'(bus.level),   int'(m_level));
        chk("count",   int'(bus.count),   int'(m_count));
        chk("ovf",     int'(bus.ovf),     int'(m_ovf));
        chk("timeout", int'(bus.timeout), int'(m_to));
        chk("state",   int'(bus.state),   m_state);
    end

    initial begin
        clr = 1'b1;
        bus.t_in = 1'b1; bus.en = 1'b1; bus.cnt_clr = 1'b0;
        #2 clr = 1'b0;
        tick(2);
        chk("rst count", int'(bus.count), 0);
        chk("rst state", int'(bus.state), 0);
        clr = 1'b1;
        chk("init c0", int'(bus.state), 0);
        tick(1); chk("init c1", int'(bus.state), 0);
        tick(1); chk("init c2", int'(bus.state), 0);
        tick(1); chk("arm", int'(bus.state), 2);
        chk("level hi", int'(bus.level), 1);
        chk("no pulse", int'(bus.pulse), 0);
        tick(6);

        for (int i = 0; i < 5; i++) begin
            bus.t_in = ~bus.t_in;
            tick(2); chk("lat E+1", int'(bus.pulse), 0);
            tick(1); chk("lat E+2", int'(bus.pulse), 1);
            tick(1); chk("lat E+3", int'(bus.pulse), 0);
        end
        chk("count5", int'(bus.count), 5);
        chk("to0", int'(bus.timeout), 0);

        tick(14);
        chk("P+15 state", int'(bus.state), 3);
        chk("P+15 to", int'(bus.timeout), 0);
        tick(1);
        chk("P+16 state", int'(bus.state), 4);
        chk("P+16 to", int'(bus.timeout), 1);
        bus.t_in = ~bus.t_in;
        tick(3);
        chk("resume state", int'(bus.state), 3);
        chk("resume count", int'(bus.count), 6);
        chk("resume to", int'(bus.timeout), 1);

        tick(2);
        bus.cnt_clr = 1'b1; tick(1); bus.cnt_clr = 1'b0;
        chk("clr count", int'(bus.count), 0);
        chk("clr to", int'(bus.timeout), 0);

        for (int i = 0; i < 17; i++) begin
            bus.t_in = ~bus.t_in;
            tick(2);
        end
        tick(2);
        chk("wrap count", int'(bus.count), 1);
        chk("wrap ovf", int'(bus.ovf), 1);

        bus.t_in = ~bus.t_in;
        tick(2);
        bus.cnt_clr = 1'b1; tick(1); bus.cnt_clr = 1'b0;
        chk("clr+inc pulse", int'(bus.pulse), 1);
        chk("clr+inc count", int'(bus.count), 1);
        chk("clr+inc ovf", int'(bus.ovf), 0);

        tick(3);
        bus.en = 1'b0;
        tick(4); bus.t_in = ~bus.t_in;
        tick(6); bus.t_in = ~bus.t_in;
        tick(6); bus.t_in = ~bus.t_in;
        tick(4);
        chk("idle state", int'(bus.state), 1);
        bus.en = 1'b1;
        tick(4);
        chk("reen count", int'(bus.count), 1);
        bus.t_in = ~bus.t_in;
        tick(3); chk("reen pulse", int'(bus.pulse), 1);
        tick(1); chk("reen single", int'(bus.pulse), 0);
        chk("reen count2", int'(bus.count), 2);

        tick(3);
        bus.t_in = ~bus.t_in;
        tick(1);
        clr = 1'b0;
        #1;
        chk("abort pulse", int'(bus.pulse), 0);
        chk("abort count", int'(bus.count), 0);
        chk("abort level", int'(bus.level), 0);
        chk("abort state", int'(bus.state), 0);
        chk("abort to", int'(bus.timeout), 0);
        tick(2);
        clr = 1'b1;
        tick(6);
        chk("post count", int'(bus.count), 0);
        chk("post pulse", int'(bus.pulse), 0);
        tick(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
